// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// requester limits, owner-index width helper and one-hot encoder.
package shared_reg_arbiter_pkg;

  localparam int NREQ_MAX = 8;

  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_IDX_W = owner_w(NREQ_MAX);

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [NREQ_IDX_W-1:0] idx);
    logic [NREQ_MAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff_en_reg.sv
// WIDTH-bit storage register with load enable and asynchronous
// active-low clear; holds the shared register contents.
module dff_en_reg
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters a write into a single
// shared register per clock; a granted requester sits out the next edge.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int OW    = owner_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [OW-1:0]         q_owner,
  output logic                  q_valid
);

  logic [OW-1:0]    ptr;
  logic [OW-1:0]    ptr_next;
  logic [OW-1:0]    winner;
  logic [OW:0]      scan;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  gnt_next;
  logic             found;
  logic [WIDTH-1:0] lane;

  // The previous grant doubles as the turnaround mask.
  always_comb begin
    elig   = req & ~gnt;
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (OW+1)'(k);
      if (scan >= (OW+1)'(NREQ)) begin
        scan = scan - (OW+1)'(NREQ);
      end
      if (!found && elig[scan[OW-1:0]]) begin
        found  = 1'b1;
        winner = scan[OW-1:0];
      end
    end
  end

  // Constant-index mux keeps unselected lanes (including X) away from q.
  always_comb begin
    lane = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == OW'(i)) begin
        lane = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    gnt_next = '0;
    ptr_next = ptr;
    if (found) begin
      gnt_next = NREQ'(onehot(NREQ_IDX_W'(winner)));
      ptr_next = (winner == OW'(NREQ-1)) ? '0 : winner + OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= '0;
      ptr     <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
    end else begin
      gnt <= gnt_next;
      ptr <= ptr_next;
      if (found) begin
        q_owner <= winner;
        q_valid <= 1'b1;
      end
    end
  end

  dff_en_reg #(
    .WIDTH (WIDTH)
  ) u_q (
    .clk (clk),
    .rst (rst),
    .en  (found),
    .d   (lane),
    .q   (q)
  );

endmodule
